// File: rtl/moving_avg_pkg.sv
// Shared types and defaults for the moving-average window stage.
package moving_avg_pkg;

  localparam int unsigned DATA_W         = 8;
  localparam int unsigned DEPTH_LOG2_DEF = 2;
  localparam int unsigned SUM_W_DEF      = DATA_W + DEPTH_LOG2_DEF;

  typedef logic signed [DATA_W-1:0]    sample_t;
  typedef logic signed [SUM_W_DEF-1:0] sum_t;

  typedef enum logic {
    FILL,
    RUN
  } state_e;

endpackage

// File: rtl/mavg_delay_line.sv
// N-tap sample delay line with shift enable and synchronous flush; exposes the oldest tap.
module mavg_delay_line
  import moving_avg_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     shift,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] oldest
);

  logic signed [DATA_W-1:0] taps_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      for (int i = 0; i < DEPTH; i++) taps_q[i] <= '0;
    end else if (shift) begin
      taps_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) taps_q[i] <= taps_q[i-1];
    end
  end

  assign oldest = taps_q[DEPTH-1];

endmodule

// File: rtl/moving_avg_window.sv
// Sample window and running accumulator with valid/ready output register.
// MAVG_ROUND_EN selects round-half-up averaging (saturating) instead of a floor shift.
module moving_avg_window #(
  parameter int unsigned DATA_W     = moving_avg_pkg::DATA_W,
  parameter int unsigned DEPTH_LOG2 = moving_avg_pkg::DEPTH_LOG2_DEF,
  localparam int unsigned SUM_W     = DATA_W + DEPTH_LOG2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [SUM_W-1:0]  out_sum,
  output logic signed [DATA_W-1:0] out_avg,
  output logic                     filled
);
  import moving_avg_pkg::*;

  localparam int unsigned N = 1 << DEPTH_LOG2;

  logic signed [DATA_W-1:0] oldest;
  logic signed [SUM_W-1:0]  sum_q;
  logic signed [SUM_W-1:0]  sum_next;
  logic signed [DATA_W-1:0] avg_next;
  logic [DEPTH_LOG2-1:0]    cnt_q;
  state_e                   state_q;
  logic                     accept;
  logic                     last_fill;
  logic                     produce;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready && !clear;
  assign last_fill = (cnt_q == DEPTH_LOG2'(N - 1));
  assign produce   = accept && ((state_q == RUN) || last_fill);

  // Taps start at zero, so the subtracted oldest tap is 0 while filling.
  assign sum_next = sum_q + {{DEPTH_LOG2{in_data[DATA_W-1]}}, in_data}
                          - {{DEPTH_LOG2{oldest[DATA_W-1]}}, oldest};

`ifdef MAVG_ROUND_EN
  localparam logic [SUM_W:0] Half = (SUM_W + 1)'(1) << (DEPTH_LOG2 - 1);

  logic signed [SUM_W:0] rnd_sum;
  logic signed [SUM_W:0] rnd_shift;
  logic                  rnd_sat;

  assign rnd_sum   = {sum_next[SUM_W-1], sum_next} + Half;
  assign rnd_shift = rnd_sum >>> DEPTH_LOG2;
  // Only the positive side can exceed the sample range after rounding.
  assign rnd_sat   = !rnd_shift[SUM_W] && (|rnd_shift[SUM_W-1:DATA_W-1]);
  assign avg_next  = rnd_sat ? {1'b0, {(DATA_W-1){1'b1}}} : rnd_shift[DATA_W-1:0];
`else
  assign avg_next = DATA_W'(sum_next >>> DEPTH_LOG2);
`endif

  mavg_delay_line #(
    .DATA_W (DATA_W),
    .DEPTH  (N)
  ) u_delay_line (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .shift  (accept),
    .din    (in_data),
    .oldest (oldest)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q     <= '0;
      cnt_q     <= '0;
      state_q   <= FILL;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_avg   <= '0;
      filled    <= 1'b0;
    end else if (clear) begin
      sum_q     <= '0;
      cnt_q     <= '0;
      state_q   <= FILL;
      out_valid <= 1'b0;
      filled    <= 1'b0;
    end else begin
      if (accept) begin
        sum_q <= sum_next;
        if (state_q == FILL) begin
          cnt_q <= cnt_q + 1'b1;
          if (last_fill) begin
            state_q <= RUN;
            filled  <= 1'b1;
          end
        end
      end
      if (produce) begin
        out_valid <= 1'b1;
        out_sum   <= sum_next;
        out_avg   <= avg_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_moving_avg_window.sv
// Bench for moving_avg_window: window-level reference model plus directed literal checks.
module tb_moving_avg_window;

  localparam int DATA_W     = 8;
  localparam int DEPTH_LOG2 = 2;
  localparam int SUM_W      = DATA_W + DEPTH_LOG2;
  localparam int N          = 1 << DEPTH_LOG2;

  logic                     clk       = 1'b0;
  logic                     rst_n     = 1'b0;
  logic                     clear     = 1'b0;
  logic                     in_valid  = 1'b0;
  logic                     out_ready = 1'b1;
  logic signed [DATA_W-1:0] in_data   = '0;
  logic                     in_ready;
  logic                     out_valid;
  logic                     filled;
  logic signed [SUM_W-1:0]  out_sum;
  logic signed [DATA_W-1:0] out_avg;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  moving_avg_window #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_avg   (out_avg),
    .filled    (filled)
  );

  task automatic chk(input string nm, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: whole window kept as plain integers, sum recomputed from scratch.
  int win [N];
  int m_cnt    = 0;
  bit m_valid  = 1'b0;
  bit m_filled = 1'b0;
  int m_sum    = 0;
  int m_avg    = 0;

  function automatic int floor_div(input int s);
    int q;
    q = s / N;
    if ((s % N != 0) && (s < 0)) q--;
    return q;
  endfunction

  function automatic int expect_avg(input int s);
    int q;
`ifdef MAVG_ROUND_EN
    q = floor_div(s + N / 2);
    if (q > 127) q = 127;
`else
    q = floor_div(s);
`endif
    return q;
  endfunction

  always @(posedge clk) begin
    bit acc;
    int s;
    acc = in_valid && (!m_valid || out_ready) && !clear;
    if (!rst_n || clear) begin
      for (int i = 0; i < N; i++) win[i] = 0;
      m_cnt    = 0;
      m_valid  = 1'b0;
      m_filled = 1'b0;
      if (!rst_n) begin
        m_sum = 0;
        m_avg = 0;
      end
    end else begin
      if (acc) begin
        for (int i = N - 1; i > 0; i--) win[i] = win[i-1];
        win[0] = int'(in_data);
        if (m_cnt < N) m_cnt++;
      end
      if (acc && m_cnt == N) begin
        s = 0;
        for (int i = 0; i < N; i++) s += win[i];
        m_sum    = s;
        m_avg    = expect_avg(s);
        m_valid  = 1'b1;
        m_filled = 1'b1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_in_ready", in_ready, (!m_valid || out_ready));
      chk("m_out_valid", out_valid, m_valid);
      chk("m_filled", filled, m_filled);
      chk("m_out_sum", out_sum, m_sum);
      chk("m_out_avg", out_avg, m_avg);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d);
    in_valid = 1'b1;
    in_data  = DATA_W'(d);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_filled", filled, 0);
    chk("rst_out_sum", out_sum, 0);
    rst_n = 1'b1;

    send(10); send(20); send(30);
    chk("fill3_out_valid", out_valid, 0);
    chk("fill3_filled", filled, 0);
    send(40);
    chk("w1_out_valid", out_valid, 1);
    chk("w1_sum", out_sum, 100);
    chk("w1_avg", out_avg, 25);
    chk("w1_filled", filled, 1);

    send(50);
    chk("w2_sum", out_sum, 140);
    chk("w2_avg", out_avg, 35);
    send(-100);
    chk("w3_sum", out_sum, 20);
    chk("w3_avg", out_avg, 5);

    repeat (4) send(-128);
    chk("min_sum", out_sum, -512);
    chk("min_avg", out_avg, -128);
    repeat (4) send(127);
    chk("max_sum", out_sum, 508);
    chk("max_avg", out_avg, 127);

    repeat (3) send(0);
    send(-1);
    chk("neg1_sum", out_sum, -1);
`ifdef MAVG_ROUND_EN
    chk("neg1_avg", out_avg, 0);
`else
    chk("neg1_avg", out_avg, -1);
`endif
    repeat (3) send(0);
    send(2);
    chk("two_sum", out_sum, 2);
`ifdef MAVG_ROUND_EN
    chk("two_avg", out_avg, 1);
`else
    chk("two_avg", out_avg, 0);
`endif

    // Stall: consumer not ready, new samples must be refused.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'sd99;
    repeat (5) begin
      tick();
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_sum", out_sum, 2);
    end
    out_ready = 1'b1;
    in_data   = 8'sd6;
    tick();
    in_valid = 1'b0;
    chk("unstall_sum", out_sum, 8);
    chk("unstall_avg", out_avg, 2);
    tick();
    chk("idle_out_valid", out_valid, 0);

    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'sd77;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_out_valid", out_valid, 0);
    chk("clr_filled", filled, 0);
    chk("clr_sum_kept", out_sum, 8);

    repeat (3) send(4);
    chk("refill_out_valid", out_valid, 0);
    send(4);
    chk("refill_sum", out_sum, 16);
    chk("refill_avg", out_avg, 4);

    send(5);
    chk("pre_rst_sum", out_sum, 17);
    rst_n = 1'b0;
    tick();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", out_sum, 0);
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
